// File: rtl/mul_pkg.sv
// Shared types and constants for the MUL command scheduler.
// Compute-word field offsets are the single source for hazard decode.
package mul_pkg;

  localparam int ROW_NUM = 16;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 16;
  localparam int CMP_W   = 25;

  localparam int CMP_SPEC_BIT = 24;
  localparam int CMP_MODE_LSB = 21;
  localparam int CMP_LEN_LSB  = 18;
  localparam int CMP_RS1_LSB  = 12;
  localparam int CMP_RS2_LSB  = 6;
  localparam int CMP_RD_LSB   = 0;

  typedef enum logic [1:0] {
    CMD_LOAD    = 2'b00,
    CMD_STORE   = 2'b01,
    CMD_COMPUTE = 2'b10,
    CMD_RSVD    = 2'b11
  } cmd_type_e;

  typedef enum logic {
    IDLE     = 1'b0,
    CMP_WAIT = 1'b1
  } sched_state_e;

  typedef struct packed {
    cmd_type_e         kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [CMP_W-1:0]  compute;
  } cmd_t;

  // True when a row address collides with any operand of a compute word.
  function automatic logic addr_hazard(
    input logic [ADDR_W-1:0] a,
    input logic [CMP_W-1:0]  w
  );
    return (a == w[CMP_RS1_LSB +: ADDR_W]) ||
           (a == w[CMP_RS2_LSB +: ADDR_W]) ||
           (a == w[CMP_RD_LSB  +: ADDR_W]);
  endfunction

endpackage

// File: rtl/mul_cmd_scheduler_if.sv
// Host command channel: valid/ready handshake plus command payload.
// The host is the master; the scheduler is the slave.
interface mul_cmd_scheduler_if;
  import mul_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [CMP_W-1:0]  cmd_compute;

  modport master (
    output cmd_valid,
    output cmd_type,
    output cmd_addr,
    output cmd_wdata,
    output cmd_compute,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_type,
    input  cmd_addr,
    input  cmd_wdata,
    input  cmd_compute,
    output cmd_ready
  );

endinterface

// File: rtl/mul_cmd_fifo.sv
// Parameterised synchronous FIFO, first-word fall-through read port.
// Pointers carry one wrap bit so full/empty need no separate counter.
module mul_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata   = mem[rptr[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mul_cmd_scheduler.sv
// In-order command scheduler for the MUL controller: load/store strobes,
// one pending compute with operand hazard stalls, store responses.
module mul_cmd_scheduler
  import mul_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  mul_cmd_scheduler_if.slave cmd,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ExLdSt_valid,
  output logic [ADDR_W:0]   ExLdSt_command,
  output logic [DATA_W-1:0] ExLdSt_wdata,
  input  logic [DATA_W-1:0] ExLdSt_rdata,
  output logic              Compute_valid,
  input  logic              Compute_ready,
  output logic [CMP_W-1:0]  Compute_command,
  output logic              busy
);

  localparam int ENTRY_W = $bits(cmd_t);

  cmd_t               in_cmd;
  cmd_t               head;
  logic [ENTRY_W-1:0] head_bits;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  sched_state_e       state;
  sched_state_e       state_nxt;
  logic [CMP_W-1:0]   pend;
  logic               pend_load;
  logic               ldst_issue;
  logic               cmp_done;
  logic               head_ldst;
  logic               head_cmp;
  logic               head_rsvd;
  logic               is_load;
  logic               is_store;

  assign in_cmd = '{
    kind:    cmd_type_e'(cmd.cmd_type),
    addr:    cmd.cmd_addr,
    wdata:   cmd.cmd_wdata,
    compute: cmd.cmd_compute
  };

  // Full refuses new work even if the head pops this cycle.
  assign cmd.cmd_ready = ~full & ~rst;
  assign push          = cmd.cmd_valid & cmd.cmd_ready;

  mul_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_cmd),
    .pop   (pop),
    .rdata (head_bits),
    .full  (full),
    .empty (empty)
  );

  assign head      = cmd_t'(head_bits);
  assign is_load   = (head.kind == CMD_LOAD);
  assign is_store  = (head.kind == CMD_STORE);
  assign head_ldst = ~empty & (is_load | is_store);
  assign head_cmp  = ~empty & (head.kind == CMD_COMPUTE);
  assign head_rsvd = ~empty & (head.kind == CMD_RSVD);
  assign cmp_done  = (state == CMP_WAIT) & Compute_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    ldst_issue = 1'b0;
    pend_load  = 1'b0;
    unique case (1'b1)
      head_ldst: begin
        if (state == IDLE || !addr_hazard(head.addr, pend)) begin
          ldst_issue = 1'b1;
          pop        = 1'b1;
        end
      end
      head_cmp: begin
        // A completing handshake frees the slot in the same cycle.
        if (state == IDLE || cmp_done) begin
          pend_load = 1'b1;
          pop       = 1'b1;
        end
      end
      head_rsvd: pop = 1'b1;
      default: ;
    endcase
    if (pend_load)     state_nxt = CMP_WAIT;
    else if (cmp_done) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
    end else begin
      if (pend_load) pend <= head.compute;
      rsp_valid <= ldst_issue & is_store;
      if (ldst_issue && is_store) begin
        rsp_addr <= head.addr;
        rsp_data <= ExLdSt_rdata;
      end
    end
  end

  assign ExLdSt_valid    = ldst_issue;
  assign ExLdSt_command  = ldst_issue ? {is_load, head.addr} : '0;
  assign ExLdSt_wdata    = (ldst_issue && is_load) ? head.wdata : '0;
  assign Compute_valid   = (state == CMP_WAIT);
  assign Compute_command = pend;
  assign busy            = ~empty | (state == CMP_WAIT) | rsp_valid;

endmodule
